// File: rtl/dequant_out_stage.sv
// Dequantization output stage: rescales signed Q16.16 column accumulators by per-column
// scales, rounds, saturates, applies optional ReLU and streams results through a small FIFO.
module dequant_out_stage #(
  parameter int N_COL      = 4,
  parameter int ACC_W      = 32,
  parameter int SCALE_W    = 16,
  parameter int SCALE_FRAC = 8,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int COL_W     = (N_COL > 1) ? $clog2(N_COL) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    scale_we_i,
  input  logic [COL_W-1:0]        scale_idx_i,
  input  logic [SCALE_W-1:0]      scale_din_i,
  input  logic                    relu_en_i,
  input  logic                    start_i,
  input  logic                    acc_valid_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic                    acc_ready_o,
  output logic                    dout_valid_o,
  output logic signed [OUT_W-1:0] dout_o,
  input  logic                    dout_ready_i,
  output logic                    sat_o,
  output logic                    done_o
);

  localparam int PROD_W = ACC_W + SCALE_W + 1;
  localparam int R_W    = PROD_W - SCALE_FRAC;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) <<< (SCALE_FRAC - 1);
  localparam logic signed [R_W-1:0] R_MAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] R_MIN = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [R_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] sum;
    sum = (p + RND_HALF) >>> SCALE_FRAC;
    return R_W'(sum);
  endfunction

  function automatic logic sat_hit(input logic signed [R_W-1:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [R_W-1:0] r);
    if (r > R_MAX) return {1'b0, {(OUT_W-1){1'b1}}};
    if (r < R_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    return r[OUT_W-1:0];
  endfunction

  logic                    rdy_en_q, rdy_en_d;
  logic [COL_W-1:0]        col_q, col_d, col_in;
  logic                    sat_q, sat_d;
  logic [SCALE_W-1:0]      scale_q [N_COL];
  logic [SCALE_W-1:0]      scale_d [N_COL];
  logic                    vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0] acc_p0_q, acc_p0_d;
  logic [SCALE_W-1:0]      scale_p0_q, scale_p0_d;
  logic [COL_W-1:0]        col_p0_q, col_p0_d, col_p1_q, col_p1_d;
  logic                    relu_p0_q, relu_p0_d, relu_p1_q, relu_p1_d;
  logic signed [PROD_W-1:0] prod_p1_q, prod_p1_d;
  logic signed [R_W-1:0]   rnd_p2;
  logic signed [OUT_W-1:0] res_p2;
  logic                    sat_p2;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [OUT_W-1:0] mem_data_q [FIFO_DEPTH];
  logic signed [OUT_W-1:0] mem_data_d [FIFO_DEPTH];
  logic [COL_W-1:0]        mem_col_q [FIFO_DEPTH];
  logic [COL_W-1:0]        mem_col_d [FIFO_DEPTH];
  logic [CNT_W:0]          credit;
  logic                    accept, push, pop;

  // Credit covers FIFO occupancy plus every beat still in the pipeline, so nothing is dropped
  assign credit       = {1'b0, cnt_q} + (CNT_W+1)'(vld_p0_q) + (CNT_W+1)'(vld_p1_q);
  assign acc_ready_o  = rdy_en_q && (credit < (CNT_W+1)'(FIFO_DEPTH));
  assign accept       = acc_valid_i && acc_ready_o;
  assign col_in       = start_i ? '0 : col_q;
  assign push         = vld_p1_q;
  assign dout_valid_o = (cnt_q != '0);
  assign pop          = dout_valid_o && dout_ready_i;
  assign dout_o       = dout_valid_o ? mem_data_q[rd_ptr_q] : '0;
  assign done_o       = pop && (mem_col_q[rd_ptr_q] == COL_W'(N_COL - 1));
  assign sat_o        = sat_q;

  always_comb begin
    rdy_en_d = 1'b1;
    col_d    = col_q;
    if (accept)
      col_d = (col_in == COL_W'(N_COL - 1)) ? '0 : col_in + COL_W'(1);
    else if (start_i)
      col_d = '0;
    sat_d = start_i ? 1'b0 : sat_q;
    if (push && sat_p2)
      sat_d = 1'b1;
    scale_d = scale_q;
    if (scale_we_i)
      scale_d[scale_idx_i] = scale_din_i;
    vld_p0_d = accept;
    vld_p1_d = vld_p0_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Stage 1: capture beat, its column tag and the scale currently held for that column
  always_comb begin
    acc_p0_d   = acc_i;
    scale_p0_d = scale_q[col_in];
    col_p0_d   = col_in;
    relu_p0_d  = relu_en_i;
  end

  // Stage 2: signed product with the scale zero-extended to stay non-negative
  always_comb begin
    prod_p1_d = $signed({{(PROD_W-ACC_W){acc_p0_q[ACC_W-1]}}, acc_p0_q})
              * $signed({{(PROD_W-SCALE_W){1'b0}}, scale_p0_q});
    col_p1_d  = col_p0_q;
    relu_p1_d = relu_p0_q;
  end

  // Stage 3: round, saturate, ReLU, then write into the FIFO
  always_comb begin
    rnd_p2 = round_shift(prod_p1_q);
    sat_p2 = sat_hit(rnd_p2);
    res_p2 = saturate(rnd_p2);
    if (relu_p1_q && res_p2[OUT_W-1])
      res_p2 = '0;
    mem_data_d = mem_data_q;
    mem_col_d  = mem_col_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = res_p2;
      mem_col_d[wr_ptr_q]  = col_p1_q;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rdy_en_q <= 1'b0;
      col_q    <= '0;
      sat_q    <= 1'b0;
      scale_q  <= '{default: '0};
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      col_q    <= col_d;
      sat_q    <= sat_d;
      scale_q  <= scale_d;
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_p0_q   <= acc_p0_d;
    scale_p0_q <= scale_p0_d;
    col_p0_q   <= col_p0_d;
    relu_p0_q  <= relu_p0_d;
    prod_p1_q  <= prod_p1_d;
    col_p1_q   <= col_p1_d;
    relu_p1_q  <= relu_p1_d;
    mem_data_q <= mem_data_d;
    mem_col_q  <= mem_col_d;
  end

endmodule

// File: tb/tb_dequant_out_stage.sv
// Directed bench for dequant_out_stage: hand-computed results for scaling, rounding,
// saturation, ReLU, backpressure, frame/scale edges and mid-frame reset.
module tb_dequant_out_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        scale_we_i;
  logic [1:0]  scale_idx_i;
  logic [15:0] scale_din_i;
  logic        relu_en_i;
  logic        start_i;
  logic        acc_valid_i;
  logic [31:0] acc_i;
  logic        acc_ready_o;
  logic        dout_valid_o;
  logic [31:0] dout_o;
  logic        dout_ready_i;
  logic        sat_o;
  logic        done_o;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [31:0] out_q[$];
  logic [31:0] e5 [10] = '{32'h00010000, 32'h00008000, 32'h00020000, 32'h00004000,
                           32'h00010000, 32'h00008000, 32'h00010000, 32'h00008000,
                           32'h00040000, 32'h00004000};

  dequant_out_stage dut (
    .clk          (clk),
    .rstn         (rstn),
    .scale_we_i   (scale_we_i),
    .scale_idx_i  (scale_idx_i),
    .scale_din_i  (scale_din_i),
    .relu_en_i    (relu_en_i),
    .start_i      (start_i),
    .acc_valid_i  (acc_valid_i),
    .acc_i        (acc_i),
    .acc_ready_o  (acc_ready_o),
    .dout_valid_o (dout_valid_o),
    .dout_o       (dout_o),
    .dout_ready_i (dout_ready_i),
    .sat_o        (sat_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Output monitor samples mid-cycle, well clear of the rising edge
  always @(negedge clk) begin
    #2;
    if (!rstn && dout_valid_o && dout_ready_i) out_q.push_back(dout_o);
    if (done_o) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = 'x;
    if (idx < out_q.size()) got = out_q[idx];
    check_eq(tag, got, exp);
  endtask

  task automatic wr_scale(input logic [1:0] idx, input logic [15:0] val);
    scale_we_i = 1'b1; scale_idx_i = idx; scale_din_i = val;
    @(negedge clk);
    scale_we_i = 1'b0;
  endtask

  // Presents one beat from a falling edge and returns on the falling edge after it is taken
  task automatic send(input logic [31:0] a, input logic st, input logic we = 1'b0,
                      input logic [1:0] idx = 2'd0, input logic [15:0] din = 16'h0);
    int waited;
    waited = 0;
    acc_valid_i = 1'b1; acc_i = a; start_i = st;
    scale_we_i = we; scale_idx_i = idx; scale_din_i = din;
    #1;
    while (!acc_ready_o && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 50) check_eq("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    acc_valid_i = 1'b0; start_i = 1'b0; scale_we_i = 1'b0;
  endtask

  initial begin
    int ob;
    int db;
    int accepted;
    logic rdy;
    rstn = 1'b1; scale_we_i = 1'b0; scale_idx_i = '0; scale_din_i = '0;
    relu_en_i = 1'b0; start_i = 1'b0; acc_valid_i = 1'b0; acc_i = '0; dout_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_acc_ready", 32'(acc_ready_o), 32'd0);
    check_eq("rst_dout_valid", 32'(dout_valid_o), 32'd0);
    check_eq("rst_dout", dout_o, 32'd0);
    check_eq("rst_sat", 32'(sat_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    #1 check_eq("rdy_at_release", 32'(acc_ready_o), 32'd0);
    @(negedge clk);
    check_eq("rdy_after_release", 32'(acc_ready_o), 32'd1);

    // 1: rounding/scaling and latency
    ob = out_q.size(); db = done_cnt;
    wr_scale(2'd0, 16'h0080);
    send(32'h00030000, 1'b1);
    check_eq("lat_cyc1", 32'(dout_valid_o), 32'd0);
    @(negedge clk);
    check_eq("lat_cyc2", 32'(dout_valid_o), 32'd0);
    @(negedge clk);
    check_eq("lat_cyc3", 32'(dout_valid_o), 32'd1);
    check_eq("lat_data", dout_o, 32'h00018000);
    @(negedge clk);
    send(32'h00000001, 1'b1);
    send(32'hFFFFFFFF, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("t1_count", 32'(out_q.size() - ob), 32'd3);
    chk_out("t1_half", ob + 0, 32'h00018000);
    chk_out("t1_round_up", ob + 1, 32'h00000001);
    chk_out("t1_neg_round", ob + 2, 32'h00000000);
    check_eq("t1_sat", 32'(sat_o), 32'd0);
    check_eq("t1_done", 32'(done_cnt - db), 32'd0);

    // 2: saturation and sticky flag cleared by start
    ob = out_q.size();
    wr_scale(2'd1, 16'h0200);
    send(32'h00000000, 1'b1);
    send(32'h40000000, 1'b0);
    repeat (8) @(negedge clk);
    chk_out("t2_pos_sat", ob + 1, 32'h7FFFFFFF);
    check_eq("t2_sat_set", 32'(sat_o), 32'd1);
    send(32'h00000000, 1'b1);
    check_eq("t2_sat_clr", 32'(sat_o), 32'd0);
    send(32'hC0000000, 1'b0);
    repeat (8) @(negedge clk);
    chk_out("t2_neg_min", ob + 3, 32'h80000000);
    check_eq("t2_no_sat_min", 32'(sat_o), 32'd0);

    // 3: ReLU
    ob = out_q.size();
    wr_scale(2'd0, 16'h0100);
    relu_en_i = 1'b1;
    send(32'hFFFB0000, 1'b1);
    send(32'h00020000, 1'b1);
    relu_en_i = 1'b0;
    send(32'hFFFB0000, 1'b1);
    repeat (8) @(negedge clk);
    chk_out("t3_relu_neg", ob + 0, 32'h00000000);
    chk_out("t3_relu_pos", ob + 1, 32'h00020000);
    chk_out("t3_norelu_neg", ob + 2, 32'hFFFB0000);

    // 4: backpressure, credit limit and in-order drain
    ob = out_q.size(); db = done_cnt;
    for (int i = 0; i < 4; i++) wr_scale(2'(i), 16'h0100);
    dout_ready_i = 1'b0;
    accepted = 0;
    acc_valid_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      acc_i = 32'(accepted + 1) << 16; start_i = (accepted == 0);
      #1 rdy = acc_ready_o;
      @(negedge clk);
      if (rdy) accepted++;
    end
    check_eq("t4_accepted_stall", 32'(accepted), 32'd4);
    check_eq("t4_ready_low", 32'(acc_ready_o), 32'd0);
    dout_ready_i = 1'b1;
    for (int c = 0; c < 40 && accepted < 8; c++) begin
      acc_i = 32'(accepted + 1) << 16; start_i = (accepted == 0);
      #1 rdy = acc_ready_o;
      @(negedge clk);
      if (rdy) accepted++;
    end
    acc_valid_i = 1'b0; start_i = 1'b0;
    check_eq("t4_accepted_all", 32'(accepted), 32'd8);
    repeat (12) @(negedge clk);
    check_eq("t4_count", 32'(out_q.size() - ob), 32'd8);
    for (int i = 0; i < 8; i++) chk_out($sformatf("t4_out%0d", i), ob + i, 32'(i + 1) << 16);
    check_eq("t4_done", 32'(done_cnt - db), 32'd2);

    // 5: per-column scales, same-cycle write, wrap, start with beat
    ob = out_q.size(); db = done_cnt;
    wr_scale(2'd0, 16'h0100);
    wr_scale(2'd1, 16'h0080);
    wr_scale(2'd2, 16'h0200);
    wr_scale(2'd3, 16'h0040);
    send(32'h00010000, 1'b1);
    send(32'h00010000, 1'b0);
    send(32'h00010000, 1'b0, 1'b1, 2'd2, 16'h0400);
    send(32'h00010000, 1'b0);
    send(32'h00010000, 1'b0);
    send(32'h00010000, 1'b0);
    send(32'h00010000, 1'b1);
    send(32'h00010000, 1'b0);
    send(32'h00010000, 1'b0);
    send(32'h00010000, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("t5_count", 32'(out_q.size() - ob), 32'd10);
    for (int i = 0; i < 10; i++) chk_out($sformatf("t5_out%0d", i), ob + i, e5[i]);
    check_eq("t5_done", 32'(done_cnt - db), 32'd2);

    // 6: reset mid-frame
    db = done_cnt;
    dout_ready_i = 1'b0;
    send(32'h00010000, 1'b1);
    send(32'h00010000, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("t6_pre_valid", 32'(dout_valid_o), 32'd1);
    rstn = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(dout_valid_o), 32'd0);
    check_eq("t6_rst_dout", dout_o, 32'd0);
    check_eq("t6_rst_ready", 32'(acc_ready_o), 32'd0);
    check_eq("t6_rst_done", 32'(done_o), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    dout_ready_i = 1'b1;
    @(negedge clk);
    check_eq("t6_no_done", 32'(done_cnt - db), 32'd0);
    ob = out_q.size();
    wr_scale(2'd0, 16'h0100);
    wr_scale(2'd1, 16'h0080);
    wr_scale(2'd2, 16'h0200);
    wr_scale(2'd3, 16'h0040);
    for (int i = 0; i < 4; i++) send(32'h00010000, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("t6_count", 32'(out_q.size() - ob), 32'd4);
    for (int i = 0; i < 4; i++) chk_out($sformatf("t6_out%0d", i), ob + i, e5[i]);
    check_eq("t6_done", 32'(done_cnt - db), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
